// File: rtl/cossim_load_sequencer.sv
// Load sequencer for the cosine-similarity wrapper: streams vct1/vct2 from the embedding RAM and captures the result.
// Optional macro COSSIM_THRESH_EN adds a thresh input and a registered match output (result >= thresh).
module cossim_load_sequencer #(
    parameter int unsigned D_Len       = 32,
    parameter int unsigned Ele_Num     = 128,
    parameter int unsigned AW          = 10,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             reuse_ref,
    input  logic [AW-1:0]    base1,
    input  logic [AW-1:0]    base2,
    output logic             busy,
    output logic             ref_valid,
    output logic             res_valid,
    output logic [D_Len-1:0] res_data,
    output logic             timeout_err,
    output logic             mem_rd_en,
    output logic [AW-1:0]    mem_addr,
    input  logic [D_Len-1:0] mem_rdata,
    output logic             cs_we,
    output logic [1:0]       cs_vct_sel,
    output logic [D_Len-1:0] cs_data_in,
    input  logic             cs_load_ready,
    input  logic [D_Len-1:0] cs_result,
`ifdef COSSIM_THRESH_EN
    input  logic [D_Len-1:0] thresh,
    output logic             match,
`endif
    input  logic             cs_done
);

    localparam int unsigned IW = (Ele_Num > 1) ? $clog2(Ele_Num) : 1;
    localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_XFER, S_WAIT_DONE} state_e;

    state_e             state_q;
    logic [1:0]         phase_q;
    logic [IW-1:0]      idx_q;
    logic [WW-1:0]      wdog_q;
    logic               loaded_q;
    logic [AW-1:0]      base1_q, base2_q;
    logic               busy_q, ref_valid_q, res_valid_q, timeout_err_q;
    logic [D_Len-1:0]   res_data_q, cs_data_in_q;
    logic               mem_rd_en_q, cs_we_q;
    logic [AW-1:0]      mem_addr_q;
    logic [1:0]         cs_vct_sel_q;

    logic               last_c, xfer_c, wd_exp_c;
    logic [IW-1:0]      idx_nxt_c;
    logic [AW-1:0]      cur_base_c;

    always_comb begin
        last_c     = (idx_q == IW'(Ele_Num - 1));
        xfer_c     = (state_q == S_XFER) && cs_we_q && cs_load_ready;
        wd_exp_c   = (wdog_q == WW'(TIMEOUT_CYC - 1));
        idx_nxt_c  = idx_q + IW'(1);
        cur_base_c = (phase_q == 2'd1) ? base1_q : base2_q;
    end

`ifdef COSSIM_THRESH_EN
    logic match_q;

    // IEEE-754 ordering on raw words, NaNs excluded
    function automatic logic thresh_ge(input logic [D_Len-1:0] r, input logic [D_Len-1:0] t);
        logic ge;
        case ({r[D_Len-1], t[D_Len-1]})
            2'b00:   ge = (r >= t);
            2'b01:   ge = 1'b1;
            2'b10:   ge = (r[D_Len-2:0] == '0) && (t[D_Len-2:0] == '0);
            default: ge = (r <= t);
        endcase
        return ge;
    endfunction
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            phase_q       <= 2'd0;
            idx_q         <= '0;
            wdog_q        <= '0;
            loaded_q      <= 1'b0;
            base1_q       <= '0;
            base2_q       <= '0;
            busy_q        <= 1'b0;
            ref_valid_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            res_data_q    <= '0;
            cs_data_in_q  <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            cs_we_q       <= 1'b0;
            cs_vct_sel_q  <= 2'd0;
`ifdef COSSIM_THRESH_EN
            match_q       <= 1'b0;
`endif
        end else begin
            mem_rd_en_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base1_q     <= base1;
                        base2_q     <= base2;
                        busy_q      <= 1'b1;
                        idx_q       <= '0;
                        wdog_q      <= '0;
                        mem_rd_en_q <= 1'b1;
                        state_q     <= S_FETCH;
                        if (reuse_ref && ref_valid_q) begin
                            phase_q    <= 2'd2;
                            mem_addr_q <= base2;
                        end else begin
                            phase_q     <= 2'd1;
                            ref_valid_q <= 1'b0;
                            mem_addr_q  <= base1;
                        end
                    end
                end
                S_FETCH: begin
                    state_q  <= S_XFER;
                    wdog_q   <= '0;
                    loaded_q <= 1'b0;
                end
                S_XFER: begin
                    if (xfer_c) begin
                        cs_we_q      <= 1'b0;
                        cs_vct_sel_q <= 2'd0;
                        wdog_q       <= '0;
                        if (!last_c) begin
                            idx_q       <= idx_nxt_c;
                            mem_rd_en_q <= 1'b1;
                            mem_addr_q  <= cur_base_c + AW'(idx_nxt_c);
                            state_q     <= S_FETCH;
                        end else if (phase_q == 2'd1) begin
                            ref_valid_q <= 1'b1;
                            phase_q     <= 2'd2;
                            idx_q       <= '0;
                            mem_rd_en_q <= 1'b1;
                            mem_addr_q  <= base2_q;
                            state_q     <= S_FETCH;
                        end else begin
                            state_q <= S_WAIT_DONE;
                        end
                    end else if (wd_exp_c) begin
                        timeout_err_q <= 1'b1;
                        ref_valid_q   <= 1'b0;
                        cs_we_q       <= 1'b0;
                        cs_vct_sel_q  <= 2'd0;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end else begin
                        wdog_q <= wdog_q + WW'(1);
                        // RAM data lands the cycle after the read strobe; capture it once
                        if (!loaded_q) begin
                            cs_data_in_q <= mem_rdata;
                            cs_we_q      <= 1'b1;
                            cs_vct_sel_q <= phase_q;
                            loaded_q     <= 1'b1;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (cs_done) begin
                        res_data_q  <= cs_result;
                        res_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
`ifdef COSSIM_THRESH_EN
                        match_q     <= thresh_ge(cs_result, thresh);
`endif
                    end else if (wd_exp_c) begin
                        timeout_err_q <= 1'b1;
                        ref_valid_q   <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end else begin
                        wdog_q <= wdog_q + WW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign ref_valid   = ref_valid_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign timeout_err = timeout_err_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_addr    = mem_addr_q;
    assign cs_we       = cs_we_q;
    assign cs_vct_sel  = cs_vct_sel_q;
    assign cs_data_in  = cs_data_in_q;
`ifdef COSSIM_THRESH_EN
    assign match       = match_q;
`endif

endmodule

// File: tb/tb_cossim_load_sequencer.sv
// Self-checking bench for cossim_load_sequencer: RAM model, expected-transfer scoreboard, directed scenarios.
// Define COSSIM_THRESH_EN to also exercise the threshold compare.
module tb_cossim_load_sequencer;

    localparam int unsigned D_LEN = 32;
    localparam int unsigned ELE   = 128;
    localparam int unsigned AW    = 10;
    localparam int unsigned TMO   = 4096;

    logic              clk = 1'b0;
    logic              rst, start, reuse_ref;
    logic [AW-1:0]     base1, base2;
    logic              busy, ref_valid, res_valid, timeout_err, mem_rd_en, cs_we;
    logic [D_LEN-1:0]  res_data, mem_rdata, cs_data_in, cs_result;
    logic [AW-1:0]     mem_addr;
    logic [1:0]        cs_vct_sel;
    logic              cs_load_ready, cs_done;
`ifdef COSSIM_THRESH_EN
    logic [D_LEN-1:0]  thresh;
    logic              match;
`endif

    always #5 clk = ~clk;

    cossim_load_sequencer #(.D_Len(D_LEN), .Ele_Num(ELE), .AW(AW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .reuse_ref(reuse_ref),
        .base1(base1), .base2(base2), .busy(busy), .ref_valid(ref_valid),
        .res_valid(res_valid), .res_data(res_data), .timeout_err(timeout_err),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .cs_we(cs_we), .cs_vct_sel(cs_vct_sel), .cs_data_in(cs_data_in),
        .cs_load_ready(cs_load_ready), .cs_result(cs_result),
`ifdef COSSIM_THRESH_EN
        .thresh(thresh), .match(match),
`endif
        .cs_done(cs_done)
    );

    // Embedding RAM: one-cycle read latency
    logic [D_LEN-1:0] mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h5A00_0000 + 32'(i) * 32'h0001_0003;
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    // Scoreboard and bookkeeping
    logic [AW-1:0]    exp_addr[$];
    logic [1:0]       exp_sel[$];
    logic [D_LEN-1:0] exp_dat[$];
    int total = 0, bad = 0;
    int xfer_cnt = 0, sel1_cnt = 0, sel2_cnt = 0, res_pulses = 0, rd_cnt = 0;
    logic [AW-1:0] first_addr = '0, last_addr = '0;
    logic res_allow = 1'b0;
    logic [31:0] exp_res = '0;
    bit model_ref = 1'b0;
    bit mon_en = 1'b0;
    int rdy_mode = 0, stall_at = 0, cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endtask

`ifdef COSSIM_THRESH_EN
    function automatic bit model_ge(input logic [31:0] r, input logic [31:0] t);
        return $bitstoshortreal(r) >= $bitstoshortreal(t);
    endfunction
`endif

    // Compare process: reads, transfers, stall stability, result pulses
    initial begin
        logic stall_prev;
        logic [D_LEN-1:0] stall_dat;
        stall_prev = 1'b0;
        stall_dat  = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (mem_rd_en) begin
                    if (rd_cnt == 0) first_addr = mem_addr;
                    last_addr = mem_addr;
                    rd_cnt++;
                    check("read_expected", 32'(exp_addr.size() != 0), 32'd1);
                    if (exp_addr.size() != 0) check("mem_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
                end
                if (cs_we && stall_prev) check("data_stable", cs_data_in, stall_dat);
                if (cs_we && cs_load_ready) begin
                    xfer_cnt++;
                    if (cs_vct_sel == 2'd1) sel1_cnt++;
                    if (cs_vct_sel == 2'd2) sel2_cnt++;
                    check("xfer_expected", 32'(exp_sel.size() != 0), 32'd1);
                    if (exp_sel.size() != 0) begin
                        check("vct_sel", 32'(cs_vct_sel), 32'(exp_sel.pop_front()));
                        check("xfer_data", cs_data_in, exp_dat.pop_front());
                    end
                end
                stall_prev = cs_we && !cs_load_ready;
                stall_dat  = cs_data_in;
                if (res_valid) begin
                    res_pulses++;
                    check("res_allowed", 32'(res_allow), 32'd1);
                    check("res_data", res_data, exp_res);
`ifdef COSSIM_THRESH_EN
                    check("match_model", 32'(match), 32'(model_ge(exp_res, thresh)));
`endif
                end
            end
        end
    end

    // load_ready driver: 0 = always, 1 = one cycle in three, 2 = stop after stall_at transfers
    initial begin
        forever begin
            @(posedge clk); #1;
            cyc++;
            case (rdy_mode)
                0:       cs_load_ready = 1'b1;
                1:       cs_load_ready = (cyc % 3 == 0);
                2:       cs_load_ready = (xfer_cnt < stall_at);
                default: cs_load_ready = 1'b0;
            endcase
        end
    end

    task automatic do_start(input bit reuse, input logic [AW-1:0] b1, input logic [AW-1:0] b2);
        logic [AW-1:0] a;
        if (!(reuse && model_ref)) begin
            model_ref = 1'b0;
            for (int k = 0; k < int'(ELE); k++) begin
                a = b1 + AW'(k);
                exp_addr.push_back(a); exp_sel.push_back(2'd1); exp_dat.push_back(mem[a]);
            end
        end
        for (int k = 0; k < int'(ELE); k++) begin
            a = b2 + AW'(k);
            exp_addr.push_back(a); exp_sel.push_back(2'd2); exp_dat.push_back(mem[a]);
        end
        @(posedge clk); #1;
        start = 1'b1; reuse_ref = reuse; base1 = b1; base2 = b2;
        @(posedge clk); #1;
        start = 1'b0; reuse_ref = 1'b0; base1 = '0; base2 = '0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_sel.size() != 0 && n < limit) begin
            @(negedge clk); #1;
            n++;
        end
        check("drain_in_time", 32'(exp_sel.size() == 0), 32'd1);
        model_ref = 1'b1;
    endtask

    task automatic finish_result(input logic [31:0] r);
        int p0 = res_pulses;
        @(negedge clk); #1;
        check("busy_wait_done", 32'(busy), 32'd1);
        check("we_low_wait", 32'({cs_we, cs_vct_sel}), 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        cs_result = r; cs_done = 1'b1; exp_res = r; res_allow = 1'b1;
        @(posedge clk); #1;
        cs_done = 1'b0; cs_result = '0;
        check("res_latency", 32'(res_valid), 32'd1);
        @(negedge clk); #1;
        check("res_pulses", 32'(res_pulses - p0), 32'd1);
        @(posedge clk); #1;
        check("res_one_cycle", 32'(res_valid), 32'd0);
        check("busy_cleared", 32'(busy), 32'd0);
        check("res_held", res_data, r);
        check("ref_valid_after", 32'(ref_valid), 32'(model_ref));
        res_allow = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int s1, s2, p0, r0, n;
        rst = 1'b0; start = 1'b0; reuse_ref = 1'b0; base1 = '0; base2 = '0;
        cs_load_ready = 1'b1; cs_result = '0; cs_done = 1'b0;
`ifdef COSSIM_THRESH_EN
        thresh = 32'h3f4c_cccd;
`endif
        #12;
        check("reset_ctrl", 32'({busy, ref_valid, res_valid, timeout_err, mem_rd_en, cs_we, cs_vct_sel}), 32'd0);
        check("reset_res_data", res_data, 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk); rst = 1'b1;
        mon_en = 1'b1;

        // Full load, ready tied high, plus an ignored start while busy
        s1 = sel1_cnt; s2 = sel2_cnt; rd_cnt = 0;
        do_start(1'b0, 10'd0, 10'd128);
        check("busy_after_start", 32'(busy), 32'd1);
        repeat (20) @(posedge clk);
        #1; start = 1'b1; reuse_ref = 1'b1; base1 = 10'd500; base2 = 10'd600;
        @(posedge clk); #1; start = 1'b0; reuse_ref = 1'b0; base1 = '0; base2 = '0;
        wait_drain(2000);
        check("full_sel1_count", 32'(sel1_cnt - s1), 32'd128);
        check("full_sel2_count", 32'(sel2_cnt - s2), 32'd128);
        check("full_first_addr", 32'(first_addr), 32'd0);
        check("full_last_addr", 32'(last_addr), 32'd255);
        finish_result(32'h3f80_0000);
        check("full_res_literal", res_data, 32'h3f80_0000);
        check("full_ref_valid", 32'(ref_valid), 32'd1);

        // Reuse: vct2 only
        s1 = sel1_cnt; s2 = sel2_cnt;
        do_start(1'b1, 10'd0, 10'd128);
        wait_drain(2000);
        check("reuse_sel1_count", 32'(sel1_cnt - s1), 32'd0);
        check("reuse_sel2_count", 32'(sel2_cnt - s2), 32'd128);
        finish_result(32'h3e99_999a);

        // Backpressure, with a stray cs_done mid-load
        rdy_mode = 1;
        s1 = sel1_cnt; s2 = sel2_cnt;
        do_start(1'b0, 10'd300, 10'd700);
        repeat (40) @(posedge clk);
        #1; cs_done = 1'b1; cs_result = 32'hdead_beef;
        @(posedge clk); #1; cs_done = 1'b0; cs_result = '0;
        wait_drain(4000);
        rdy_mode = 0;
        check("bp_sel1_count", 32'(sel1_cnt - s1), 32'd128);
        check("bp_sel2_count", 32'(sel2_cnt - s2), 32'd128);
        finish_result(32'h1234_5678);

        // Watchdog: stall at element 5 of phase 1
        stall_at = xfer_cnt + 5;
        rdy_mode = 2;
        p0 = res_pulses; r0 = rd_cnt;
        do_start(1'b0, 10'd40, 10'd200);
        check("tmo_ref_cleared", 32'(ref_valid), 32'd0);
        n = 0;
        while (xfer_cnt < stall_at && n < 2000) begin @(negedge clk); #1; n++; end
        n = 0;
        while (!timeout_err && n < 5000) begin @(negedge clk); #1; n++; end
        check("tmo_seen", 32'(timeout_err), 32'd1);
        check("tmo_window", 32'(n >= 4090 && n <= 4110), 32'd1);
        @(negedge clk); #1;
        check("tmo_one_cycle", 32'(timeout_err), 32'd0);
        check("tmo_ref_valid", 32'(ref_valid), 32'd0);
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_we", 32'({cs_we, cs_vct_sel}), 32'd0);
        check("tmo_no_res", 32'(res_pulses - p0), 32'd0);
        check("tmo_reads", 32'(rd_cnt - r0), 32'd6);
        exp_addr.delete(); exp_sel.delete(); exp_dat.delete();
        model_ref = 1'b0;
        rdy_mode = 0;

        // reuse_ref without a resident reference -> full load, both bases wrapping
        s1 = sel1_cnt; s2 = sel2_cnt;
        do_start(1'b1, 10'd900, 10'd1000);
        wait_drain(2000);
        check("wrap_sel1_count", 32'(sel1_cnt - s1), 32'd128);
        check("wrap_sel2_count", 32'(sel2_cnt - s2), 32'd128);
        check("wrap_last_addr", 32'(last_addr), 32'd103);

        // Async reset while in WAIT_DONE
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check("arst_ctrl", 32'({busy, ref_valid, res_valid, timeout_err, mem_rd_en, cs_we, cs_vct_sel}), 32'd0);
        check("arst_res_data", res_data, 32'd0);
        check("arst_cs_data", cs_data_in, 32'd0);
        check("arst_mem_addr", 32'(mem_addr), 32'd0);
        model_ref = 1'b0;
        @(negedge clk); rst = 1'b1;
        p0 = res_pulses;
        @(posedge clk); #1; cs_done = 1'b1; cs_result = 32'h4000_0000;
        @(posedge clk); #1; cs_done = 1'b0; cs_result = '0;
        repeat (5) @(negedge clk);
        #1;
        check("arst_no_res", 32'(res_pulses - p0), 32'd0);
        check("arst_idle_busy", 32'(busy), 32'd0);

`ifdef COSSIM_THRESH_EN
        do_start(1'b0, 10'd0, 10'd128);
        wait_drain(2000);
        finish_result(32'h3f66_6666);
        check("match_0p9", 32'(match), 32'd1);
        do_start(1'b1, 10'd0, 10'd128);
        wait_drain(2000);
        finish_result(32'h3f00_0000);
        check("match_0p5", 32'(match), 32'd0);
        do_start(1'b1, 10'd0, 10'd128);
        wait_drain(2000);
        finish_result(32'hbf00_0000);
        check("match_neg", 32'(match), 32'd0);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
